// File: rtl/spram_pkg.sv
// ============================================================================
// spram_pkg : shared types and limits for the pipelined single-port RAM.
// Rev 1.0
// ============================================================================
`default_nettype none

package spram_pkg;

   typedef enum logic [1:0] {
      READ_FIRST  = 2'd0,
      WRITE_FIRST = 2'd1,
      NO_CHANGE   = 2'd2
   } write_mode_e;

   localparam int MaxReadLatency = 4;

endpackage

`default_nettype wire

// File: rtl/spram_if.sv
// ============================================================================
// spram_if : request/response bus of spram_pipe (err only with SPRAM_BOUNDS_CHECK_EN).
// Rev 1.0
// ============================================================================
`default_nettype none

interface spram_if
   import spram_pkg::*;
#(
   parameter int AddrBusWidth = 32,
   parameter int DataBusWidth = 32
);
   logic                      re;
   logic [AddrBusWidth-1:0]   addr;
   logic                      we;
   logic [DataBusWidth/8-1:0] w_strb;
   logic [DataBusWidth-1:0]   w_data;
   logic [DataBusWidth-1:0]   r_data;
   logic                      r_valid;
`ifdef SPRAM_BOUNDS_CHECK_EN
   logic                      err;

   modport master (output re, addr, we, w_strb, w_data, input r_data, r_valid, err);
   modport slave  (input re, addr, we, w_strb, w_data, output r_data, r_valid, err);
`else
   modport master (output re, addr, we, w_strb, w_data, input r_data, r_valid);
   modport slave  (input re, addr, we, w_strb, w_data, output r_data, r_valid);
`endif
endinterface

`default_nettype wire

// File: rtl/spram_delay.sv
// ============================================================================
// spram_delay : valid/data register pipeline; each stage loads only on valid so
// the final stage holds the last result.
// Rev 1.0
// ============================================================================
`default_nettype none

module spram_delay
   import spram_pkg::*;
#(
   parameter int Width  = 32,
   parameter int Stages = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [Width-1:0] in_data,
   output logic             out_valid,
   output logic [Width-1:0] out_data
);

   if (Stages < 1 || Stages > MaxReadLatency - 1) begin : g_bad_stages
      $error("spram_delay: Stages out of range");
   end

   logic             vld [Stages];
   logic [Width-1:0] dat [Stages];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < Stages; i++) begin
            vld[i] <= 1'b0;
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < Stages; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[Stages-1];
   assign out_data  = dat[Stages-1];

endmodule

`default_nettype wire

// File: rtl/spram_pipe.sv
// ============================================================================
// spram_pipe : single-port RAM with byte strobes and 1..4 cycle read pipeline.
// Optional macro SPRAM_BOUNDS_CHECK_EN adds out-of-range detection and err.
// Rev 1.0
// ============================================================================
`default_nettype none

module spram_pipe
   import spram_pkg::*;
#(
   parameter string       MemoryInitFile = "none",
   parameter int          AddrBusWidth   = 32,
   parameter int          DataBusWidth   = 32,
   parameter int          MemSizeBytes   = 2048,
   parameter int          ReadLatency    = 1,
   parameter write_mode_e WriteMode      = READ_FIRST
) (
   input  logic   clk,
   input  logic   rst,
   spram_if.slave bus
);

   localparam int StrbW = DataBusWidth / 8;
   localparam int Depth = MemSizeBytes / StrbW;
   localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
`ifdef SPRAM_BOUNDS_CHECK_EN
   localparam int PipeW = DataBusWidth + 1;
`else
   localparam int PipeW = DataBusWidth;
`endif

   if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
      $error("spram_pipe: ReadLatency must be 1..%0d", MaxReadLatency);
   end
   if (DataBusWidth % 8 != 0) begin : g_bad_width
      $error("spram_pipe: DataBusWidth must be a multiple of 8");
   end
   if (Depth < 1 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("spram_pipe: Depth must be a power of two");
   end

   logic [DataBusWidth-1:0] mem [Depth];

   logic [IdxW-1:0]         idx;
   logic                    in_range;
   logic                    wr_en;
   logic                    rd_fire;
   logic [DataBusWidth-1:0] rd_word;
   logic [DataBusWidth-1:0] merged;
   logic [PipeW-1:0]        rd_next;

   assign idx = bus.addr[IdxW-1:0];
`ifdef SPRAM_BOUNDS_CHECK_EN
   assign in_range = (bus.addr < AddrBusWidth'(Depth));
`else
   assign in_range = 1'b1;
`endif

   always_comb begin
      rd_word = mem[idx];
      merged  = rd_word;
      for (int i = 0; i < StrbW; i++) begin
         if (bus.w_strb[i]) merged[8*i +: 8] = bus.w_data[8*i +: 8];
      end
      wr_en   = bus.we & in_range;
      rd_fire = bus.re & ~(bus.we & (WriteMode == NO_CHANGE));
      rd_next = '0;
      if (in_range) begin
         rd_next[DataBusWidth-1:0] = (WriteMode == WRITE_FIRST && bus.we) ? merged : rd_word;
      end
`ifdef SPRAM_BOUNDS_CHECK_EN
      rd_next[DataBusWidth] = ~in_range;
`endif
   end

   // Array has no reset; writes are only blocked while rst is high.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         for (int i = 0; i < StrbW; i++) begin
            if (bus.w_strb[i]) mem[idx][8*i +: 8] <= bus.w_data[8*i +: 8];
         end
      end
   end

   logic             s0_valid;
   logic [PipeW-1:0] s0_data;
   logic             out_valid;
   logic [PipeW-1:0] out_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_data  <= '0;
      end else begin
         s0_valid <= rd_fire;
         if (rd_fire) s0_data <= rd_next;
      end
   end

   if (ReadLatency > 1) begin : g_delay
      spram_delay #(
         .Width  (PipeW),
         .Stages (ReadLatency - 1)
      ) u_delay (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (s0_valid),
         .in_data   (s0_data),
         .out_valid (out_valid),
         .out_data  (out_data)
      );
   end else begin : g_direct
      assign out_valid = s0_valid;
      assign out_data  = s0_data;
   end

   assign bus.r_valid = out_valid;
   assign bus.r_data  = out_data[DataBusWidth-1:0];

`ifdef SPRAM_BOUNDS_CHECK_EN
   // Write errors report the cycle after the write; read errors ride with their data.
   logic wr_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_err <= 1'b0;
      else     wr_err <= bus.we & ~in_range;
   end

   assign bus.err = wr_err | (out_valid & out_data[DataBusWidth]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_spram_pipe.sv
// ============================================================================
// tb_spram_pipe : three spram_pipe instances (RL1/READ_FIRST, RL3/WRITE_FIRST,
// RL4/NO_CHANGE) driven in lockstep and compared with a queue-based model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spram_pipe;
   import spram_pkg::*;

   localparam int Depth = 512;
   localparam int RL [3] = '{1, 3, 4};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_re = 1'b0, s_we = 1'b0;
   logic [31:0] s_addr = '0, s_wdata = '0;
   logic [3:0]  s_strb = '0;

   spram_if #(.AddrBusWidth(32), .DataBusWidth(32)) bus0 ();
   spram_if #(.AddrBusWidth(32), .DataBusWidth(32)) bus1 ();
   spram_if #(.AddrBusWidth(32), .DataBusWidth(32)) bus2 ();

   assign bus0.re = s_re;  assign bus0.we = s_we;  assign bus0.addr = s_addr;
   assign bus0.w_strb = s_strb;  assign bus0.w_data = s_wdata;
   assign bus1.re = s_re;  assign bus1.we = s_we;  assign bus1.addr = s_addr;
   assign bus1.w_strb = s_strb;  assign bus1.w_data = s_wdata;
   assign bus2.re = s_re;  assign bus2.we = s_we;  assign bus2.addr = s_addr;
   assign bus2.w_strb = s_strb;  assign bus2.w_data = s_wdata;

   spram_pipe #(.ReadLatency(1), .WriteMode(READ_FIRST))  u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   spram_pipe #(.ReadLatency(3), .WriteMode(WRITE_FIRST)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   spram_pipe #(.ReadLatency(4), .WriteMode(NO_CHANGE))   u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

   logic        rv  [3];
   logic [31:0] rdv [3];
   assign rv[0] = bus0.r_valid;  assign rdv[0] = bus0.r_data;
   assign rv[1] = bus1.r_valid;  assign rdv[1] = bus1.r_data;
   assign rv[2] = bus2.r_valid;  assign rdv[2] = bus2.r_data;
`ifdef SPRAM_BOUNDS_CHECK_EN
   logic er [3];
   assign er[0] = bus0.err;  assign er[1] = bus1.err;  assign er[2] = bus2.err;
`endif

   // Model: word array plus, per instance, the results still owed and the edge they are due.
   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        q    [3][$];
   logic [31:0] last [3];
   logic [31:0] mmem [Depth];
   logic        werr = 1'b0;
   int          cyc = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r = (r & ~(32'hFF << (8*b))) | (nw & (32'hFF << (8*b)));
      end
      return r;
   endfunction

   task automatic model_edge();
      bit          oob;
      int          idx;
      logic [31:0] old, nw, rd;
      oob = 1'b0;
`ifdef SPRAM_BOUNDS_CHECK_EN
      oob = (s_addr >= 32'(Depth));
`endif
      idx  = int'(s_addr % 32'(Depth));
      old  = mmem[idx];
      nw   = merge(old, s_wdata, s_strb);
      werr = s_we && oob;
      if (s_re) begin
         for (int d = 0; d < 3; d++) begin
            if (!(s_we && d == 2)) begin
               rd = (d == 1 && s_we) ? nw : old;
               if (oob) rd = '0;
               q[d].push_back('{due: cyc + RL[d] - 1, data: rd, err: oob});
            end
         end
      end
      if (s_we && !oob) mmem[idx] = nw;
   endtask

   task automatic check_all();
      exp_t e;
      logic ee;
      for (int d = 0; d < 3; d++) begin
         ee = 1'b0;
         if (q[d].size() > 0 && q[d][0].due == cyc) begin
            e = q[d].pop_front();
            chk($sformatf("d%0d_valid", d), 32'(rv[d]), 32'd1);
            chk($sformatf("d%0d_data", d), rdv[d], e.data);
            last[d] = e.data;
            ee = e.err;
         end else begin
            chk($sformatf("d%0d_idle", d), 32'(rv[d]), 32'd0);
            chk($sformatf("d%0d_hold", d), rdv[d], last[d]);
         end
`ifdef SPRAM_BOUNDS_CHECK_EN
         chk($sformatf("d%0d_err", d), 32'(er[d]), 32'(ee | werr));
`else
         ee = ee | werr;
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!rst) model_edge();
      else      werr = 1'b0;
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit re, input bit we, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] data);
      s_re = re;  s_we = we;  s_addr = addr;  s_strb = strb;  s_wdata = data;
      tick();
   endtask

   task automatic drive_random();
      logic [31:0] a;
      a = 32'($urandom_range(0, 15));
`ifndef SPRAM_BOUNDS_CHECK_EN
      a = a + 32'(Depth) * 32'($urandom_range(0, 3));
`endif
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a,
            4'($urandom), $urandom);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) last[d] = '0;

      repeat (2) tick();
      #2 rst = 1'b0;

      for (int a = 0; a < 16; a++) drive(1'b0, 1'b1, 32'(a), 4'hF, $urandom);
      drive(1'b0, 1'b1, 32'd88, 4'hF, $urandom);

      drive(1'b0, 1'b1, 32'd5, 4'hF, 32'hDEADBEEF);
      drive(1'b1, 1'b0, 32'd5, 4'h0, 32'h0);
      drive(1'b0, 1'b1, 32'd2, 4'hF, 32'h11223344);
      drive(1'b0, 1'b1, 32'd2, 4'h5, 32'hAABBCCDD);
      drive(1'b1, 1'b0, 32'd2, 4'h0, 32'h0);
      for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, 32'(a), 4'h0, 32'h0);
      drive(1'b0, 1'b1, 32'd9, 4'hF, 32'h1);
      drive(1'b1, 1'b1, 32'd9, 4'hF, 32'h2);
      repeat (5) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      repeat (300) drive_random();

      // Reads in flight when reset hits must vanish; memory must survive.
      drive(1'b1, 1'b0, 32'd3, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 32'd4, 4'h0, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_rst_valid", d), 32'(rv[d]), 32'd0);
         chk($sformatf("d%0d_rst_data", d), rdv[d], 32'd0);
         q[d].delete();
         last[d] = '0;
      end
      drive(1'b1, 1'b1, 32'd3, 4'hF, 32'h12345678);
      drive(1'b1, 1'b1, 32'd4, 4'hF, 32'h9ABCDEF0);
      #2 rst = 1'b0;
      for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, 32'(a), 4'h0, 32'h0);

      repeat (200) drive_random();

`ifdef SPRAM_BOUNDS_CHECK_EN
      drive(1'b0, 1'b1, 32'd600, 4'hF, 32'h2);
      drive(1'b1, 1'b0, 32'd600, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 32'd88, 4'h0, 32'h0);
`endif
      repeat (6) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_drain", d), 32'(q[d].size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
